// File: rtl/mux_rr_valid.sv
// Registered N:1 mux with per-channel valid: fixed-select or round-robin grant, one-cycle latency, no backpressure.
// Optional MUX_RR_COUNT_EN adds a saturating 8-bit count of valid output cycles.
module mux_rr_valid #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [SEL_W-1:0]          select,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_chan
`ifdef MUX_RR_COUNT_EN
    ,
    output logic [7:0]                out_count
`endif
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] chan_q, chan_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic fix_hit, rr_hi, rr_any, found;
    int   fix_g, rr_hi_g, rr_lo_g, g;

    always_comb begin
        fix_hit = 1'b0;
        fix_g   = 0;
        rr_hi   = 1'b0;
        rr_any  = 1'b0;
        rr_hi_g = 0;
        rr_lo_g = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (select == SEL_W'(i) && in_valid[i]) begin
                fix_hit = 1'b1;
                fix_g   = i;
            end
        end
        // Descending scan: the last hit is the lowest index, at or above ptr for rr_hi_g.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                rr_any  = 1'b1;
                rr_lo_g = i;
                if (i >= int'(ptr_q)) begin
                    rr_hi   = 1'b1;
                    rr_hi_g = i;
                end
            end
        end
        if (mode) begin
            found = rr_any;
            g     = rr_hi ? rr_hi_g : rr_lo_g;
        end else begin
            found = fix_hit;
            g     = fix_g;
        end
    end

    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (found) begin
            valid_d = 1'b1;
            chan_d  = SEL_W'(g);
            ptr_d   = (g == CHANNELS - 1) ? '0 : SEL_W'(g + 1);
            for (int i = 0; i < CHANNELS; i++) begin
                if (i == g) data_d = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_chan  = chan_q;

`ifdef MUX_RR_COUNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else if (valid_d && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_valid.sv
// Bench for mux_rr_valid (WIDTH=2, CHANNELS=4): per-cycle model compare plus literal checks.
module tb_mux_rr_valid;

    localparam int W = 2;
    localparam int C = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [C*W-1:0] in_data = '0;
    logic [C-1:0]   in_valid = '0;
    logic [S-1:0]   select = '0;
    logic           mode = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [S-1:0]   out_chan;
`ifdef MUX_RR_COUNT_EN
    logic [7:0]     out_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mux_rr_valid #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .select   (select),
        .mode     (mode),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_chan (out_chan)
`ifdef MUX_RR_COUNT_EN
        ,
        .out_count(out_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: outputs as plain integers, pointer as channel number.
    int m_data = 0, m_valid = 0, m_chan = 0, m_ptr = 0, m_count = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data = 0; m_valid = 0; m_chan = 0; m_ptr = 0; m_count = 0;
        end else begin
            int win;
            win = -1;
            if (mode == 1'b0) begin
                if (in_valid[select]) win = int'(select);
            end else begin
                for (int k = 0; k < C; k++) begin
                    int cand;
                    cand = (m_ptr + k) % C;
                    if (win < 0 && in_valid[cand]) win = cand;
                end
            end
            if (win >= 0) begin
                m_data  = (in_data >> (win * W)) & ((1 << W) - 1);
                m_valid = 1;
                m_chan  = win;
                m_ptr   = (win + 1) % C;
                if (m_count < 255) m_count++;
            end else begin
                m_data  = 0;
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_data", int'(out_data), m_data);
        check("model_valid", int'(out_valid), m_valid);
        check("model_chan", int'(out_chan), m_chan);
`ifdef MUX_RR_COUNT_EN
        check("model_count", int'(out_count), m_count);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int d, input int v, input int ch);
        check({name, "_data"}, int'(out_data), d);
        check({name, "_valid"}, int'(out_valid), v);
        check({name, "_chan"}, int'(out_chan), ch);
    endtask

    typedef struct {
        logic       md;
        logic [1:0] sel;
        logic [3:0] vld;
    } vec_t;

    vec_t vecs[10];
    int   rr_exp[5];
    int   sp_exp[4];

    initial begin
        vecs[0] = '{1'b0, 2'd3, 4'b1000};
        vecs[1] = '{1'b1, 2'd0, 4'b0111};
        vecs[2] = '{1'b1, 2'd0, 4'b0111};
        vecs[3] = '{1'b0, 2'd0, 4'b1110};
        vecs[4] = '{1'b1, 2'd2, 4'b1001};
        vecs[5] = '{1'b1, 2'd2, 4'b1001};
        vecs[6] = '{1'b0, 2'd1, 4'b0010};
        vecs[7] = '{1'b1, 2'd0, 4'b0100};
        vecs[8] = '{1'b1, 2'd0, 4'b0000};
        vecs[9] = '{1'b1, 2'd3, 4'b1111};
        rr_exp = '{0, 1, 2, 3, 0};
        sp_exp = '{1, 3, 1, 3};

        tick();
        tick();
        expect_out("reset_hold", 0, 0, 0);
        reset = 1'b1;

        // Fixed mode: channel 2 carries 2'b11.
        mode = 1'b0; select = 2'd2; in_valid = 4'b0100;
        in_data = 8'b0011_0000;
        tick();
        expect_out("fixed_hit", 3, 1, 2);
        in_valid = 4'b0000;
        tick();
        expect_out("fixed_drop", 0, 0, 2);

        // Traffic, then reset asserted mid-cycle must clear outputs at once.
        in_valid = 4'b0100;
        tick();
        expect_out("pre_reset", 3, 1, 2);
        #2 reset = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0);
        tick();
        reset = 1'b1;

        // Round-robin, all valid, channel i data = i.
        mode = 1'b1; in_valid = 4'b1111; in_data = 8'b11_10_01_00;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("rr_all", rr_exp[i], 1, rr_exp[i]);
        end

        // Sparse then idle then resume.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("rr_sparse", sp_exp[i], 1, sp_exp[i]);
        end
        in_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("rr_idle", 0, 0, 3);
        end
        in_valid = 4'b1010;
        tick();
        expect_out("rr_resume0", 1, 1, 1);
        tick();
        expect_out("rr_resume1", 3, 1, 3);

        // Fixed select 1 for one cycle, then round-robin picks up at 2.
        mode = 1'b0; select = 2'd1; in_valid = 4'b1111;
        tick();
        expect_out("switch_fixed", 1, 1, 1);
        mode = 1'b1;
        tick();
        expect_out("switch_rr0", 2, 1, 2);
        tick();
        expect_out("switch_rr1", 3, 1, 3);

        // Mixed vectors checked only by the model.
        in_data = 8'b01_11_10_01;
        foreach (vecs[i]) begin
            mode = vecs[i].md; select = vecs[i].sel; in_valid = vecs[i].vld;
            tick();
        end

`ifdef MUX_RR_COUNT_EN
        #2 reset = 1'b0;
        #1;
        check("count_reset", int'(out_count), 0);
        tick();
        reset = 1'b1;
        mode = 1'b1; in_valid = 4'b1111;
        tick();
        check("count_first", int'(out_count), 1);
        for (int i = 1; i < 300; i++) tick();
        check("count_sat", int'(out_count), 255);
        #2 reset = 1'b0;
        #1;
        check("count_cleared", int'(out_count), 0);
        tick();
        reset = 1'b1;
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
